// File: rtl/reg_file_if.sv
// Register-file port bundle: write-back, two read ports and the pending-write scoreboard.
// master drives indices/data (issue/write-back side); slave is the register file itself.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_addr;
    logic              busy_a;
    logic              busy_b;

    modport master (
        output we, wr_addr, wr_data, rd_addr_a, rd_addr_b, busy_set, busy_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b
    );

    modport slave (
        input  we, wr_addr, wr_data, rd_addr_a, rd_addr_b, busy_set, busy_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b
    );
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file, r0 hardwired to zero, with a per-register pending-write bit.
// Define REG_FILE_BYPASS_EN to forward the in-flight write-back value and pending state to the read ports.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  rf
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0]             pending;

    // Index 0 is never written, so it holds its reset value; the read mux masks it regardless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (rf.we && (rf.wr_addr != '0)) begin
            regs[rf.wr_addr] <= rf.wr_data;
        end
    end

    // The set is issued after the clear so a same-index collision leaves the bit at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (rf.we)
                pending[rf.wr_addr] <= 1'b0;
            if (rf.busy_set && (rf.busy_addr != '0))
                pending[rf.busy_addr] <= 1'b1;
        end
    end

    always_comb begin
        rf.rd_data_a = (rf.rd_addr_a == '0) ? '0 : regs[rf.rd_addr_a];
        rf.rd_data_b = (rf.rd_addr_b == '0) ? '0 : regs[rf.rd_addr_b];
        rf.busy_a    = (rf.rd_addr_a == '0) ? 1'b0 : pending[rf.rd_addr_a];
        rf.busy_b    = (rf.rd_addr_b == '0) ? 1'b0 : pending[rf.rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
        if (rf.we && (rf.wr_addr != '0) && (rf.wr_addr == rf.rd_addr_a)) begin
            rf.rd_data_a = rf.wr_data;
            rf.busy_a    = rf.busy_set && (rf.busy_addr == rf.rd_addr_a);
        end
        if (rf.we && (rf.wr_addr != '0) && (rf.wr_addr == rf.rd_addr_b)) begin
            rf.rd_data_b = rf.wr_data;
            rf.busy_b    = rf.busy_set && (rf.busy_addr == rf.rd_addr_b);
        end
`endif
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset contents, write latency, r0, pending scoreboard, bypass, reset collisions.
module tb_reg_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf ();

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.we = 1'b0; rf.wr_addr = '0; rf.wr_data = '0;
        rf.busy_set = 1'b0; rf.busy_addr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rf.rd_addr_a = '0; rf.rd_addr_b = '0;
        tick(); tick();
        rst_n = 1'b1;

        // Every index reads zero / not busy after reset, both ports.
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            rf.rd_addr_a = ADDR_W'(i);
            rf.rd_addr_b = ADDR_W'((1 << ADDR_W) - 1 - i);
            #1;
            chk($sformatf("rst_da[%0d]", i), rf.rd_data_a, '0);
            chk($sformatf("rst_db[%0d]", i), rf.rd_data_b, '0);
            chk($sformatf("rst_ba[%0d]", i), {31'b0, rf.busy_a}, '0);
            chk($sformatf("rst_bb[%0d]", i), {31'b0, rf.busy_b}, '0);
        end

        // Write 5, readable on both ports next cycle.
        rf.we = 1'b1; rf.wr_addr = 5'd5; rf.wr_data = 32'hDEADBEEF;
        rf.rd_addr_a = 5'd1; rf.rd_addr_b = 5'd1;
        tick();
        idle();
        rf.rd_addr_a = 5'd5; rf.rd_addr_b = 5'd5;
        #1;
        chk("wr5_a", rf.rd_data_a, 32'hDEADBEEF);
        chk("wr5_b", rf.rd_data_b, 32'hDEADBEEF);

        // Write to r0 is discarded.
        rf.we = 1'b1; rf.wr_addr = 5'd0; rf.wr_data = 32'h12345678;
        tick();
        idle();
        rf.rd_addr_a = 5'd0;
        #1;
        chk("r0_data", rf.rd_data_a, '0);

        // busy_set on r0 is ignored.
        rf.busy_set = 1'b1; rf.busy_addr = 5'd0;
        tick();
        idle();
        #1;
        chk("r0_busy", {31'b0, rf.busy_a}, '0);

        // Pending on 7 for two cycles, then write-back clears it.
        rf.rd_addr_a = 5'd7;
        rf.busy_set = 1'b1; rf.busy_addr = 5'd7;
        tick();
        idle();
        #1;
        chk("b7_cyc1", {31'b0, rf.busy_a}, 32'd1);
        tick();
        chk("b7_cyc2", {31'b0, rf.busy_a}, 32'd1);
        rf.we = 1'b1; rf.wr_addr = 5'd7; rf.wr_data = 32'h42;
        tick();
        idle();
        #1;
        chk("b7_clr", {31'b0, rf.busy_a}, '0);
        chk("b7_data", rf.rd_data_a, 32'h42);

        // Same-cycle set and write to 9: set wins, data lands.
        rf.busy_set = 1'b1; rf.busy_addr = 5'd9;
        rf.we = 1'b1; rf.wr_addr = 5'd9; rf.wr_data = 32'h1;
        tick();
        idle();
        rf.rd_addr_a = 5'd9; rf.rd_addr_b = 5'd5;
        #1;
        chk("c9_busy", {31'b0, rf.busy_a}, 32'd1);
        chk("c9_data", rf.rd_data_a, 32'h1);
        chk("indep_b", rf.rd_data_b, 32'hDEADBEEF);
        chk("indep_bb", {31'b0, rf.busy_b}, '0);

        // Seed r3 with a value and a pending bit, then read it during its write-back.
        rf.busy_set = 1'b1; rf.busy_addr = 5'd3;
        rf.we = 1'b1; rf.wr_addr = 5'd3; rf.wr_data = 32'h11111111;
        tick();
        idle();
        rf.we = 1'b1; rf.wr_addr = 5'd3; rf.wr_data = 32'hCAFEF00D;
        rf.rd_addr_a = 5'd3; rf.rd_addr_b = 5'd3;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("byp_da", rf.rd_data_a, 32'hCAFEF00D);
        chk("byp_db", rf.rd_data_b, 32'hCAFEF00D);
        chk("byp_ba", {31'b0, rf.busy_a}, '0);
`else
        chk("byp_da", rf.rd_data_a, 32'h11111111);
        chk("byp_db", rf.rd_data_b, 32'h11111111);
        chk("byp_ba", {31'b0, rf.busy_a}, 32'd1);
`endif
        tick();
        idle();
        #1;
        chk("r3_data", rf.rd_data_a, 32'hCAFEF00D);
        chk("r3_busy", {31'b0, rf.busy_a}, '0);

        // Reset coincident with a write and busy_set on 4: both lost, everything cleared.
        rst_n = 1'b0;
        rf.we = 1'b1; rf.wr_addr = 5'd4; rf.wr_data = 32'hFFFFFFFF;
        rf.busy_set = 1'b1; rf.busy_addr = 5'd4;
        tick();
        rst_n = 1'b1;
        idle();
        rf.rd_addr_a = 5'd4; rf.rd_addr_b = 5'd5;
        #1;
        chk("rst4_data", rf.rd_data_a, '0);
        chk("rst4_busy", {31'b0, rf.busy_a}, '0);
        chk("rst5_data", rf.rd_data_b, '0);
        rf.rd_addr_b = 5'd9;
        #1;
        chk("rst9_busy", {31'b0, rf.busy_b}, '0);
        chk("rst9_data", rf.rd_data_b, '0);
        tick();
        chk("rst4_hold", rf.rd_data_a, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
